seat_reservation_ctrl: RTL and testbench
========================================

# seat_reservation_ctrl

Seat reservation controller fed by the library timer's time-of-day bus and daily-reset flag. Holds an occupancy record per seat: owner ID and end-of-reservation minute. Accepts reserve/release/extend requests over a valid/ready handshake. Expires seats by scanning on every minute tick, and wipes all seats when the daily reset condition rises.

## Interface
- NUM_SEATS, 32: number of seats; 2..256.
- USER_W, 8: user ID width.
- SEAT_W, $clog2(NUM_SEATS): seat index width (derived).
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rst_timer  in  1  daily-reset flag from the timer; a level, held for the whole matching hour.
- time_in  in  11  time of day {hour[10:6], min[5:0]}.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  00 reserve, 01 release, 10 extend, 11 illegal.
- req_seat  in  SEAT_W  target seat.
- req_user  in  USER_W  requesting user.
- req_dur  in  8  duration in minutes; 0 is illegal.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_status  out  2  00 OK, 01 BUSY, 10 NOT_OWNER, 11 BAD.
- seat_occupied  out  NUM_SEATS  per-seat occupied flags.
- free_count  out  SEAT_W+1  number of unoccupied seats.

## Operation
- Time conversion: now = hour*60 + min, 11 bits, range 0..1439. If hour > 23 or min > 59, now = 1439.
- Reserve:
  - Seat free: occupied=1, owner=req_user, end=min(now+req_dur, 1439) → OK.
  - Seat occupied: BUSY, no change.
- Release:
  - Seat occupied and owner matches: free the seat → OK.
  - Seat occupied, owner differs: NOT_OWNER.
  - Seat already free: BAD.
- Extend: seat occupied and owner matches → end=min(end+req_dur, 1439), OK. Otherwise NOT_OWNER (occupied) or BAD (free).
- BAD is also returned for op 11, req_dur==0 on reserve/extend, and req_seat ≥ NUM_SEATS.
- Reservations never wrap past midnight; saturation at 1439 is required.
- The daily clear fires on the rising edge of rst_timer, detected internally via a registered copy of rst_timer. It clears every occupied flag in one cycle. A held-high rst_timer clears only once.
- Minute tick: registered min field differs from the current min field. A tick starts an expiry scan.
- Expiry scan: visits seat 0..NUM_SEATS-1, one per cycle. It frees an occupied seat when end ≤ now, with now sampled at scan start.
- FSM states and transitions:
  - IDLE: req_ready=1.
  - EXEC: one cycle, applies the accepted request.
  - CLEAR: one cycle.
  - SCAN: NUM_SEATS cycles, then → IDLE.
- Priority in IDLE: clear edge > pending tick > request. A clear edge in any state aborts SCAN or follows EXEC, then enters CLEAR.
- A tick during SCAN or EXEC is latched as pending; multiple pending ticks merge into one scan.
- A clear edge discards any pending tick.
- free_count = NUM_SEATS − popcount(seat_occupied). It is a registered, incrementally updated count, never recomputed combinationally across all seats.

## Timing
- Reset values: req_ready=0 during reset and 1 in the first cycle after rst_n deasserts; rsp_valid=0, rsp_status=00, seat_occupied=0, free_count=NUM_SEATS, FSM=IDLE, pending tick=0. The registered rst_timer and min copies reset to 0.
- Handshake: accept when req_valid && req_ready at edge t. Request fields are captured at t. State updates and rsp_valid=1 appear at t+1. req_ready=0 at t+1, back to 1 at t+2 if no clear or scan is pending. Throughput is 1 request per 2 cycles.
- rsp_valid is asserted for exactly one cycle per accepted request and never for scan or clear.
- Clear edge sampled at t: seat_occupied=0 and free_count=NUM_SEATS visible at t+2.
- Scan latency: NUM_SEATS cycles from SCAN entry. Each freed seat's flag falls on its visit cycle +1.
- rst_n assertion mid-operation: immediate return to reset values. No response is issued for an in-flight request.

## Configuration
- SEAT_EXTEND_EN defined: op 10 behaves as Extend.
- SEAT_EXTEND_EN undefined: op 10 returns BAD with no state change. The extend adder and its saturation logic are not compiled in.

## Structure
- Package seat_pkg holds:
  - seat_op_e (RESERVE, RELEASE, EXTEND, ILLEGAL)
  - seat_status_e (OK, BUSY, NOT_OWNER, BAD)
  - fsm state enum
  - typedef minutes_t (logic [10:0])
  - constants MINUTES_PER_DAY_M1=1439 and MIN_PER_HOUR=60
- Sub-module tod_to_minutes: combinational conversion of {hour, min} → minutes_t with out-of-range saturation. It is reused for the now value.

## Test plan
- Reserve seat 3, user 0x21, dur 30, at 10:15 → rsp OK at t+1; seat_occupied[3]=1; free_count=31; end=645.
- Reserve seat 3 again by user 0x22 → BUSY. Release seat 3 by user 0x22 → NOT_OWNER. Release by user 0x21 → OK, free_count=32.
- Reserve at 23:50 with dur 30 → end saturates to 1439. Step time to 23:59 → seat freed by the scan.
- Reserve at 10:15 with dur 2, then advance min to 16, then 17 → seat still occupied after the 16 scan and freed during the 17 scan, within NUM_SEATS+1 cycles.
- Fill 5 seats and hold rst_timer high 100 cycles → all flags 0 at t+2 after the rising edge, with exactly one clear. Reserve during the high period → OK and persists.
- Extend seat by owner with dur 10 → OK, end+10 with SEAT_EXTEND_EN defined; BAD and end unchanged without it. Assert rst_n during EXEC → no rsp_valid, all outputs at reset values.

Source files
------------

// File: rtl/seat_pkg.sv
// Shared types and constants for the seat reservation controller.
package seat_pkg;

  typedef logic [10:0] minutes_t;

  localparam minutes_t    MINUTES_PER_DAY_M1 = 11'd1439;
  localparam int unsigned MIN_PER_HOUR       = 60;

  typedef enum logic [1:0] {
    OpReserve = 2'b00,
    OpRelease = 2'b01,
    OpExtend  = 2'b10,
    OpIllegal = 2'b11
  } seat_op_e;

  typedef enum logic [1:0] {
    StatOk       = 2'b00,
    StatBusy     = 2'b01,
    StatNotOwner = 2'b10,
    StatBad      = 2'b11
  } seat_status_e;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StClear,
    StScan
  } seat_state_e;

  // Adds a duration to a minute value, pinning the result at the last minute of the day.
  function automatic minutes_t sat_add(minutes_t base, logic [7:0] dur);
    logic [11:0] sum;
    sum = {1'b0, base} + {4'b0000, dur};
    return (sum > {1'b0, MINUTES_PER_DAY_M1}) ? MINUTES_PER_DAY_M1 : sum[10:0];
  endfunction

endpackage

// File: rtl/tod_to_minutes.sv
// Converts a {hour, min} time-of-day word into minutes since midnight.
// Out-of-range hour or minute fields map to the last minute of the day.
module tod_to_minutes
  import seat_pkg::*;
(
  input  logic [10:0] tod,
  output minutes_t    minutes
);

  logic [4:0] hour;
  logic [5:0] mins;

  assign hour = tod[10:6];
  assign mins = tod[5:0];

  always_comb begin
    if (hour > 5'd23 || mins > 6'd59) begin
      minutes = MINUTES_PER_DAY_M1;
    end else begin
      minutes = minutes_t'(hour) * minutes_t'(MIN_PER_HOUR) + minutes_t'(mins);
    end
  end

endmodule

// File: rtl/seat_reservation_ctrl.sv
// Seat reservation controller: reserve/release/extend, per-minute expiry scan, daily clear.
// Define SEAT_EXTEND_EN to enable the extend operation; otherwise extend answers BAD.
module seat_reservation_ctrl
  import seat_pkg::*;
#(
  parameter int unsigned NUM_SEATS = 32,
  parameter int unsigned USER_W    = 8,
  localparam int unsigned SEAT_W   = $clog2(NUM_SEATS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rst_timer,
  input  logic [10:0]          time_in,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [SEAT_W-1:0]    req_seat,
  input  logic [USER_W-1:0]    req_user,
  input  logic [7:0]           req_dur,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_status,
  output logic [NUM_SEATS-1:0] seat_occupied,
  output logic [SEAT_W:0]      free_count
);

  seat_state_e          state_q, state_d;
  logic [NUM_SEATS-1:0] occ_q;
  logic [USER_W-1:0]    owner_q [NUM_SEATS];
  minutes_t             end_q   [NUM_SEATS];
  logic                 rst_timer_q, tick_pend_q, rsp_valid_q;
  logic [5:0]           min_q;
  logic [SEAT_W-1:0]    scan_idx_q;
  minutes_t             scan_now_q, now, new_end;
  logic [SEAT_W:0]      free_cnt_q;
  seat_status_e         rsp_status_q, dec_status;
  logic clr_edge, tick, accept, scan_start, scan_last, scan_hit;
  logic seat_ok, sel_occ, sel_own, dec_set, dec_free, dec_ext;

  tod_to_minutes u_now (
    .tod     (time_in),
    .minutes (now)
  );

  assign clr_edge   = rst_timer & ~rst_timer_q;
  assign tick       = time_in[5:0] != min_q;
  assign scan_last  = scan_idx_q == SEAT_W'(NUM_SEATS - 1);
  assign scan_hit   = (state_q == StScan) && occ_q[scan_idx_q] &&
                      (end_q[scan_idx_q] <= scan_now_q);
  assign scan_start = (state_q == StIdle) && (state_d == StScan);
  assign accept     = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr_edge) begin
      state_d = StClear;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (tick || tick_pend_q) state_d = StScan;
          else if (req_valid)      state_d = StExec;
        end
        StExec, StClear: state_d = StIdle;
        StScan:          if (scan_last) state_d = StIdle;
        default:         state_d = StIdle;
      endcase
    end
  end

  // Ready is withheld while a clear or scan is about to take the idle slot.
  always_comb begin
    req_ready = 1'b0;
    if (state_q == StIdle && !clr_edge && !tick && !tick_pend_q) req_ready = rst_n;
  end

  // The request is decoded and applied on the accepting edge; EXEC is the response cycle.
  always_comb begin
    seat_ok    = {1'b0, req_seat} < (SEAT_W + 1)'(NUM_SEATS);
    sel_occ    = seat_ok & occ_q[req_seat];
    sel_own    = owner_q[req_seat] == req_user;
    dec_status = StatBad;
    dec_set    = 1'b0;
    dec_free   = 1'b0;
    dec_ext    = 1'b0;
    new_end    = sat_add(now, req_dur);
    if (seat_ok) begin
      unique case (seat_op_e'(req_op))
        OpReserve: begin
          if (req_dur != 8'd0) begin
            if (sel_occ) begin
              dec_status = StatBusy;
            end else begin
              dec_status = StatOk;
              dec_set    = 1'b1;
            end
          end
        end
        OpRelease: begin
          if (sel_occ) begin
            dec_status = sel_own ? StatOk : StatNotOwner;
            dec_free   = sel_own;
          end
        end
`ifdef SEAT_EXTEND_EN
        OpExtend: begin
          if (req_dur != 8'd0 && sel_occ) begin
            dec_status = sel_own ? StatOk : StatNotOwner;
            dec_ext    = sel_own;
            new_end    = sat_add(end_q[req_seat], req_dur);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
      for (int i = 0; i < NUM_SEATS; i++) begin
        owner_q[i] <= '0;
        end_q[i]   <= '0;
      end
    end else if (state_q == StClear) begin
      occ_q <= '0;
    end else if (accept) begin
      if (dec_set) begin
        occ_q[req_seat]   <= 1'b1;
        owner_q[req_seat] <= req_user;
      end
      if (dec_free)          occ_q[req_seat] <= 1'b0;
      if (dec_set | dec_ext) end_q[req_seat] <= new_end;
    end else if (scan_hit) begin
      occ_q[scan_idx_q] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_timer_q  <= 1'b0;
      min_q        <= '0;
      tick_pend_q  <= 1'b0;
      scan_idx_q   <= '0;
      scan_now_q   <= '0;
      free_cnt_q   <= (SEAT_W + 1)'(NUM_SEATS);
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= StatOk;
    end else begin
      rst_timer_q <= rst_timer;
      min_q       <= time_in[5:0];
      rsp_valid_q <= accept;
      if (accept) rsp_status_q <= dec_status;

      if (clr_edge || scan_start) tick_pend_q <= 1'b0;
      else if (tick)              tick_pend_q <= 1'b1;

      if (scan_start) begin
        scan_idx_q <= '0;
        scan_now_q <= now;
      end else if (state_q == StScan) begin
        scan_idx_q <= scan_idx_q + SEAT_W'(1);
      end

      if (state_q == StClear)                 free_cnt_q <= (SEAT_W + 1)'(NUM_SEATS);
      else if (accept && dec_set)             free_cnt_q <= free_cnt_q - (SEAT_W + 1)'(1);
      else if ((accept && dec_free) || scan_hit) free_cnt_q <= free_cnt_q + (SEAT_W + 1)'(1);
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_status    = rsp_status_q;
  assign seat_occupied = occ_q;
  assign free_count    = free_cnt_q;

endmodule

// File: tb/tb_seat_reservation_ctrl.sv
// Directed, table-driven bench for seat_reservation_ctrl (default 32 seats).
module tb_seat_reservation_ctrl;

  localparam int unsigned NUM_SEATS = 32;
  localparam int unsigned SEAT_W    = $clog2(NUM_SEATS);
`ifdef SEAT_EXTEND_EN
  localparam logic [1:0] EXT_FOREIGN = 2'd2;
  localparam logic [1:0] EXT_OWNER   = 2'd0;
  localparam logic       EXT_HOLD    = 1'b1;
`else
  localparam logic [1:0] EXT_FOREIGN = 2'd3;
  localparam logic [1:0] EXT_OWNER   = 2'd3;
  localparam logic       EXT_HOLD    = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n, rst_timer, req_valid, req_ready, rsp_valid;
  logic [10:0]          time_in;
  logic [1:0]           req_op, rsp_status, st;
  logic [SEAT_W-1:0]    req_seat;
  logic [7:0]           req_user, req_dur;
  logic [NUM_SEATS-1:0] seat_occupied;
  logic [SEAT_W:0]      free_count;

  int n_vec = 0, n_err = 0, n_req = 0, rsp_cnt = 0;

  seat_reservation_ctrl #(.NUM_SEATS(NUM_SEATS), .USER_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rst_timer     (rst_timer),
    .time_in       (time_in),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_seat      (req_seat),
    .req_user      (req_user),
    .req_dur       (req_dur),
    .rsp_valid     (rsp_valid),
    .rsp_status    (rsp_status),
    .seat_occupied (seat_occupied),
    .free_count    (free_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && rsp_valid) rsp_cnt++;

  typedef struct {
    logic [1:0] op;
    int         seat;
    logic [7:0] user;
    logic [7:0] dur;
    logic [1:0] status;
    logic       occ;
    int         free;
  } vec_t;

  vec_t vec[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_time(input int h, input int m);
    time_in = {5'(h), 6'(m)};
  endtask

  task automatic settle();
    repeat (NUM_SEATS + 8) step();
  endtask

  task automatic do_req(input logic [1:0] op, input int seat, input logic [7:0] user,
                        input logic [7:0] dur, output logic [1:0] status);
    int n = 0;
    while (!req_ready && n < 200) begin
      step();
      n++;
    end
    if (!req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL req_ready_wait: got 0 expected 1");
    end
    req_valid = 1'b1;
    req_op    = op;
    req_seat  = SEAT_W'(seat);
    req_user  = user;
    req_dur   = dur;
    step();
    req_valid = 1'b0;
    n_req++;
    chk("rsp_valid", 32'(rsp_valid), 1);
    status = rsp_status;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vec[0]  = '{2'd0, 3,  8'h21, 8'd30,  2'd0,        1'b1, 31};
    vec[1]  = '{2'd0, 3,  8'h22, 8'd5,   2'd1,        1'b1, 31};
    vec[2]  = '{2'd1, 3,  8'h22, 8'd0,   2'd2,        1'b1, 31};
    vec[3]  = '{2'd1, 3,  8'h21, 8'd0,   2'd0,        1'b0, 32};
    vec[4]  = '{2'd1, 3,  8'h21, 8'd0,   2'd3,        1'b0, 32};
    vec[5]  = '{2'd0, 5,  8'h10, 8'd0,   2'd3,        1'b0, 32};
    vec[6]  = '{2'd3, 5,  8'h10, 8'd5,   2'd3,        1'b0, 32};
    vec[7]  = '{2'd0, 31, 8'h44, 8'd1,   2'd0,        1'b1, 31};
    vec[8]  = '{2'd0, 0,  8'h45, 8'd255, 2'd0,        1'b1, 30};
    vec[9]  = '{2'd2, 0,  8'h46, 8'd5,   EXT_FOREIGN, 1'b1, 30};
    vec[10] = '{2'd2, 3,  8'h21, 8'd5,   2'd3,        1'b0, 30};
    vec[11] = '{2'd1, 31, 8'h44, 8'd0,   2'd0,        1'b0, 31};
    vec[12] = '{2'd1, 0,  8'h45, 8'd0,   2'd0,        1'b0, 32};

    rst_n = 1'b0; rst_timer = 1'b0; time_in = '0;
    req_valid = 1'b0; req_op = '0; req_seat = '0; req_user = '0; req_dur = '0;
    repeat (3) step();
    chk("ready_in_reset", 32'(req_ready), 0);
    rst_n = 1'b1;
    #1;
    chk("reset_ready", 32'(req_ready), 1);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_status", 32'(rsp_status), 0);
    chk("reset_occupied", seat_occupied, 0);
    chk("reset_free", 32'(free_count), 32);

    set_time(10, 15);
    settle();
    for (int i = 0; i < 13; i++) begin
      do_req(vec[i].op, vec[i].seat, vec[i].user, vec[i].dur, st);
      chk($sformatf("vec%0d_status", i), 32'(st), 32'(vec[i].status));
      chk($sformatf("vec%0d_ready_low", i), 32'(req_ready), 0);
      chk($sformatf("vec%0d_occ", i), 32'(seat_occupied[vec[i].seat]), 32'(vec[i].occ));
      chk($sformatf("vec%0d_free", i), 32'(free_count), 32'(vec[i].free));
    end

    // Expiry: seat 3 ends at 10:45 (645), seat 7 at 10:17 (617).
    do_req(2'd0, 3, 8'h21, 8'd30, st);
    chk("res3_status", 32'(st), 0);
    do_req(2'd0, 7, 8'h27, 8'd2, st);
    chk("res7_status", 32'(st), 0);
    chk("free_after_two", 32'(free_count), 30);
    set_time(10, 16);
    settle();
    chk("seat7_held_at_16", 32'(seat_occupied[7]), 1);
    set_time(10, 17);
    n = 0;
    while (seat_occupied[7] && n < 100) begin
      step();
      n++;
    end
    chk("seat7_freed_within_scan", 32'(n <= NUM_SEATS + 1), 1);
    chk("seat3_held_at_17", 32'(seat_occupied[3]), 1);
    set_time(10, 44);
    settle();
    chk("seat3_held_at_44", 32'(seat_occupied[3]), 1);
    set_time(10, 45);
    settle();
    chk("seat3_freed_at_45", 32'(seat_occupied[3]), 0);
    chk("free_after_expiry", 32'(free_count), 32);

    // Late reservation saturates at 23:59.
    set_time(23, 50);
    settle();
    do_req(2'd0, 9, 8'h09, 8'd30, st);
    chk("res9_status", 32'(st), 0);
    set_time(23, 58);
    settle();
    chk("seat9_held_at_2358", 32'(seat_occupied[9]), 1);
    set_time(23, 59);
    settle();
    chk("seat9_freed_at_2359", 32'(seat_occupied[9]), 0);

    // Daily clear with a long-held flag.
    set_time(12, 0);
    settle();
    for (int s = 10; s < 15; s++) begin
      do_req(2'd0, s, 8'(8'h50 + s), 8'd100, st);
      chk($sformatf("fill%0d_status", s), 32'(st), 0);
    end
    step();
    chk("free_before_clear", 32'(free_count), 27);
    rst_timer = 1'b1;
    repeat (3) step();
    chk("clear_occupied", seat_occupied, 0);
    chk("clear_free", 32'(free_count), 32);
    do_req(2'd0, 15, 8'h15, 8'd100, st);
    chk("res_during_high", 32'(st), 0);
    repeat (90) step();
    chk("single_clear_occ", 32'(seat_occupied[15]), 1);
    chk("single_clear_free", 32'(free_count), 31);
    rst_timer = 1'b0;
    step();

    // Extend: seat 20 ends at 12:05, or 12:15 when extended.
    do_req(2'd0, 20, 8'h30, 8'd5, st);
    chk("res20_status", 32'(st), 0);
    do_req(2'd2, 20, 8'h30, 8'd10, st);
    chk("ext20_status", 32'(st), 32'(EXT_OWNER));
    set_time(12, 5);
    settle();
    chk("seat20_at_1205", 32'(seat_occupied[20]), 32'(EXT_HOLD));
`ifdef SEAT_EXTEND_EN
    set_time(12, 15);
    settle();
    chk("seat20_at_1215", 32'(seat_occupied[20]), 0);
`endif

    // Reset during the response cycle of an accepted request.
    while (!req_ready) step();
    req_valid = 1'b1; req_op = 2'd0; req_seat = SEAT_W'(21); req_user = 8'h61; req_dur = 8'd9;
    step();
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_status", 32'(rsp_status), 0);
    chk("rst_occupied", seat_occupied, 0);
    chk("rst_free", 32'(free_count), 32);
    time_in = '0;
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 1);
    step();
    chk("rsp_pulse_count", 32'(rsp_cnt), 32'(n_req));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
